// File: rtl/register_file_2r1w_if.sv
// Bus bundle for register_file_2r1w: one write port and two read ports.
// The master side (datapath) drives addresses, write data and byte enables;
// the slave side (register file) returns registered read data and the
// out-of-range write flag.
interface register_file_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                  WE;
    logic [ADDR_W-1:0]     WrAddr;
    logic [DATA_W-1:0]     WrData;
    logic [DATA_W/8-1:0]   ByteEn;
    logic [ADDR_W-1:0]     RdAddr1;
    logic [ADDR_W-1:0]     RdAddr2;
    logic [DATA_W-1:0]     Dout1;
    logic [DATA_W-1:0]     Dout2;
    logic                  WrErr;

    modport master (
        output WE, WrAddr, WrData, ByteEn, RdAddr1, RdAddr2,
        input  Dout1, Dout2, WrErr
    );

    modport slave (
        input  WE, WrAddr, WrData, ByteEn, RdAddr1, RdAddr2,
        output Dout1, Dout2, WrErr
    );
endinterface

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: DEPTH x DATA_W register file, one byte-masked write
// port, two registered read ports (1-cycle latency).
// Optional macro REGFILE_BYPASS_EN: when defined, a read of the address being
// written on the same edge returns the merged (write-first) value; otherwise
// the pre-write value is returned (read-first).
// Entry 0 is hardwired to zero when ZERO_REG=1. Addresses >= DEPTH read as 0,
// drop writes and raise WrErr for one cycle.
module register_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input logic              Clk,
    input logic              Rst,
    register_file_2r1w_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    // Storage is rounded up to a power of two so the entry index is a plain
    // slice of the address; slots at or above DEPTH are never written or read.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 2 ** IDX_W;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [SLOTS];

    logic [DATA_W-1:0] byte_mask;
    logic              wr_any;
    logic              wr_live;
    logic              wr_oor;
    logic [DATA_W-1:0] stored_w;
    logic [DATA_W-1:0] merged_w;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    // An address is "live" when it maps to a real, writable entry.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic hard_zero;
        hard_zero = (ZERO_REG != 0) && (a == '0);
        return in_range(a) && !hard_zero;
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    // Expand per-byte enables into a bit mask over the data word.
    always_comb begin
        byte_mask = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            byte_mask[8*i +: 8] = {8{bus.ByteEn[i]}};
        end
    end

    // Write qualification, error detection and merged write value.
    always_comb begin
        wr_any   = |bus.ByteEn;
        wr_live  = bus.WE && wr_any && addr_live(bus.WrAddr);
        wr_oor   = bus.WE && wr_any && !in_range(bus.WrAddr);
        stored_w = mem[to_idx(bus.WrAddr)];
        merged_w = (stored_w & ~byte_mask) | (bus.WrData & byte_mask);
    end

    // Next read data for both ports; dead addresses read as zero.
    always_comb begin
        rd1_next = addr_live(bus.RdAddr1) ? mem[to_idx(bus.RdAddr1)] : '0;
        rd2_next = addr_live(bus.RdAddr2) ? mem[to_idx(bus.RdAddr2)] : '0;
`ifdef REGFILE_BYPASS_EN
        // wr_live already excludes hardwired-zero and out-of-range addresses.
        if (wr_live && (bus.RdAddr1 == bus.WrAddr)) begin
            rd1_next = merged_w;
        end
        if (wr_live && (bus.RdAddr2 == bus.WrAddr)) begin
            rd2_next = merged_w;
        end
`endif
    end

    // Storage update, registered read outputs and error flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
            bus.Dout1 <= '0;
            bus.Dout2 <= '0;
            bus.WrErr <= 1'b0;
        end else begin
            if (wr_live) begin
                mem[to_idx(bus.WrAddr)] <= merged_w;
            end
            bus.Dout1 <= rd1_next;
            bus.Dout2 <= rd2_next;
            bus.WrErr <= wr_oor;
        end
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w. Two instances share the same
// stimulus: dut0 (DEPTH=16, ZERO_REG=1) and dut1 (DEPTH=32, ZERO_REG=0).
// Expected read data is computed from a plain array model of each instance.
module tb_register_file_2r1w;
    localparam int DW = 32;
    localparam int AW = 5;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    register_file_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    register_file_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    register_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .ZERO_REG(1)) dut0 (
        .Clk(Clk), .Rst(Rst), .bus(bus0)
    );
    register_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .ZERO_REG(0)) dut1 (
        .Clk(Clk), .Rst(Rst), .bus(bus1)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] ref_mem [2][32];
    int passed = 0;
    int total  = 0;

    function automatic int dep(int k);
        return (k == 0) ? 16 : 32;
    endfunction

    function automatic bit zr(int k);
        return (k == 0);
    endfunction

    function automatic bit live(int k, int a);
        return (a < dep(k)) && !(zr(k) && a == 0);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(int k, int a, bit we, int wa, logic [31:0] wd, logic [3:0] be);
        if (!live(k, a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && be != 0 && wa == a) return merge(ref_mem[k][a], wd, be);
`endif
        return ref_mem[k][a];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) ref_mem[k][a] = 32'h0;
    endtask

    task automatic drive(bit we, int wa, logic [31:0] wd, logic [3:0] be, int r1, int r2);
        bus0.WE = we; bus0.WrAddr = AW'(wa); bus0.WrData = wd; bus0.ByteEn = be;
        bus0.RdAddr1 = AW'(r1); bus0.RdAddr2 = AW'(r2);
        bus1.WE = we; bus1.WrAddr = AW'(wa); bus1.WrData = wd; bus1.ByteEn = be;
        bus1.RdAddr1 = AW'(r1); bus1.RdAddr2 = AW'(r2);
    endtask

    // One clock of stimulus: drive, predict the post-edge outputs, update model.
    task automatic step(bit we, int wa, logic [31:0] wd, logic [3:0] be, int r1, int r2);
        exp_t e;
        @(negedge Clk);
        drive(we, wa, wd, be, r1, r2);
        for (int k = 0; k < 2; k++) begin
            e.d1  = model_rd(k, r1, we, wa, wd, be);
            e.d2  = model_rd(k, r2, we, wa, wd, be);
            e.err = we && (be != 0) && (wa >= dep(k));
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int k = 0; k < 2; k++)
            if (we && be != 0 && live(k, wa)) ref_mem[k][wa] = merge(ref_mem[k][wa], wd, be);
    endtask

    // Assert reset with a write pending (it must be lost), check outputs clear
    // asynchronously, hold for two edges, then release with writes idle.
    task automatic do_reset();
        @(negedge Clk);
        drive(1'b1, 3, 32'hDEADBEEF, 4'hF, 3, 3);
        Rst = 1'b1;
        #1;
        check("rst_d0_dout1", bus0.Dout1, 32'h0);
        check("rst_d0_dout2", bus0.Dout2, 32'h0);
        check("rst_d0_wrerr", {31'h0, bus0.WrErr}, 32'h0);
        check("rst_d1_dout1", bus1.Dout1, 32'h0);
        check("rst_d1_dout2", bus1.Dout2, 32'h0);
        check("rst_d1_wrerr", {31'h0, bus1.WrErr}, 32'h0);
        clear_model();
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        drive(1'b0, 0, 32'h0, 4'h0, 0, 0);
        Rst = 1'b0;
    endtask

    // Monitor: after each edge, compare outputs against the oldest prediction.
    always begin
        exp_t e;
        @(posedge Clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("d0_dout1", bus0.Dout1, e.d1);
            check("d0_dout2", bus0.Dout2, e.d2);
            check("d0_wrerr", {31'h0, bus0.WrErr}, {31'h0, e.err});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("d1_dout1", bus1.Dout1, e.d1);
            check("d1_dout2", bus1.Dout2, e.d2);
            check("d1_wrerr", {31'h0, bus1.WrErr}, {31'h0, e.err});
        end
    end

    initial begin
        int wa, r1, r2;
        drive(1'b0, 0, 32'h0, 4'h0, 0, 0);
        clear_model();
        do_reset();

        // Directed sequence.
        step(0, 0, 32'h0, 4'h0, 1, 31);
        step(1, 5, 32'hFFFFFFFF, 4'hF, 5, 5);
        step(0, 0, 32'h0, 4'h0, 5, 5);
        step(1, 5, 32'hF0F0F0F0, 4'h5, 5, 5);
        step(0, 0, 32'h0, 4'h0, 5, 5);
        step(1, 0, 32'h12345678, 4'hF, 0, 0);
        step(0, 0, 32'h0, 4'h0, 0, 0);
        step(1, 20, 32'hAAAAAAAA, 4'hF, 20, 5);
        step(0, 0, 32'h0, 4'h0, 20, 5);
        step(0, 0, 32'h0, 4'h0, 15, 1);
        step(1, 7, 32'h11111111, 4'hF, 1, 2);
        step(1, 7, 32'h22222222, 4'hF, 7, 0);
        step(0, 0, 32'h0, 4'h0, 7, 7);
        step(1, 5, 32'h0, 4'h0, 5, 5);
        step(0, 0, 32'h0, 4'h0, 5, 3);

        // Mid-simulation reset; outputs are non-zero going in.
        do_reset();
        step(0, 0, 32'h0, 4'h0, 5, 3);

        // Randomized traffic with frequent same-address collisions.
        for (int n = 0; n < 800; n++) begin
            wa = $urandom_range(0, 31);
            r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            r2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)), r1, r2);
            if (n == 400) do_reset();
        end

        step(0, 0, 32'h0, 4'h0, 0, 0);
        @(negedge Clk);
        @(negedge Clk);
        total++;
        if (q0.size() == 0 && q1.size() == 0) passed++;
        else $display("FAIL drain: %0d/%0d predictions left, expected 0/0", q0.size(), q1.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised successor to the single 32-bit write-enabled register: a multi-entry register file with one write port and two independently addressed read ports.
- Writes use per-byte enables; reads are registered with one-cycle latency.
- Entry 0 can optionally be hardwired to zero.
- Sits in the processor datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, entry width in bits; must be a multiple of 8, minimum 8
ADDR_W, 5, address width in bits
DEPTH, 32, number of implemented entries; 1 <= DEPTH <= 2**ADDR_W
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary entry

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
WE  input  1  write enable
WrAddr  input  ADDR_W  write address
WrData  input  DATA_W  write data
ByteEn  input  DATA_W/8  per-byte write mask; bit i covers WrData[8i+7:8i]
RdAddr1  input  ADDR_W  read port 1 address
RdAddr2  input  ADDR_W  read port 2 address
Dout1  output  DATA_W  read port 1 data, registered
Dout2  output  DATA_W  read port 2 data, registered
WrErr  output  1  registered flag: pulses high for one cycle after a write to an out-of-range address

Behaviour:
- One clock domain (Clk). Reset is asynchronous and active-high (Rst).
- Reset:
  - Rst high immediately clears all entries, Dout1, Dout2 and WrErr to 0, without waiting for a clock edge.
  - Reset asserted mid-write: the write is lost.
  - First write after reset is accepted on the first rising edge with Rst low.
- Write:
  - On a rising edge with WE=1, for each i with ByteEn[i]=1, entry[WrAddr] byte i <= WrData byte i.
  - Bytes with ByteEn[i]=0 keep their old value.
  - ByteEn all zero: no state change and no WrErr.
- ZERO_REG=1:
  - Writes to address 0 are discarded silently; WrErr stays 0.
  - Reads of address 0 return 0.
- Out-of-range addresses (address >= DEPTH):
  - Write: discarded; WrErr=1 for the following cycle.
  - Read: returns 0.
- Read:
  - Dout1 <= entry[RdAddr1] and Dout2 <= entry[RdAddr2] on every rising edge.
  - Latency is 1 cycle from address to data.
  - Outputs update every cycle; there is no read enable.
- Both read ports may use the same address in the same cycle; both return identical data.
- Same-edge write and read to the same address: result is defined by the optional feature below.
- Address wrap: none. Addresses are not taken modulo DEPTH.
- WrErr is asserted only by the out-of-range write condition and deasserts on the next edge unless that condition repeats.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: on a rising edge where WE=1 and WrAddr equals RdAddrN (valid, non-zero-hardwired), DoutN captures the merged value. The merged value takes bytes with ByteEn[i]=1 from WrData and all other bytes from the stored entry, i.e. write-first.
- Not defined: DoutN captures the pre-write stored value (read-first). The new value becomes visible on a read issued one cycle later.
- ZERO_REG and out-of-range rules take precedence in both modes: hardwired 0 and out-of-range addresses never bypass.

Test Plan:
- Reset then read: Rst=1 for 2 cycles, release, read addresses 1 and 31 → Dout1=Dout2=0x00000000 and WrErr=0. Assert Rst mid-simulation → outputs drop to 0 before the next edge.
- Full write and read back: write 0xFFFFFFFF to address 5 with ByteEn=4'b1111, then read 5 on both ports → one cycle later Dout1=Dout2=0xFFFFFFFF.
- Partial write: address 5 holds 0xFFFFFFFF; write 0xF0F0F0F0 with ByteEn=4'b0101 → reads of 5 return 0xFFF0FFF0.
- Zero register: ZERO_REG=1, write 0x12345678 to address 0 → read 0 returns 0 and WrErr=0. Rerun with ZERO_REG=0 → read returns 0x12345678.
- Out of range: DEPTH=16, write 0xAAAAAAAA to address 20 → WrErr=1 for exactly 1 cycle, read 20 returns 0, and entries 0..15 are unchanged.
- Collision: address 7 holds 0x11111111; on the same edge write 0x22222222 (ByteEn=4'b1111) to 7 and read 7 on port 1. With REGFILE_BYPASS_EN, Dout1=0x22222222; without it, Dout1=0x11111111 and the next read gives 0x22222222.
